// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the character-LCD bus scheduler.
package lcd_bus_pkg;

    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_EN, W_HOLD, R_SETUP, R_EN, R_HOLD, DONE
    } lcd_state_e;

    localparam logic [7:0] CLEAR       = 8'h01;
    localparam logic [7:0] HOME        = 8'h02;
    localparam logic [7:0] ENTRY_INC   = 8'h06;
    localparam logic [7:0] DISP_ON_CUR = 8'h0E;
    localparam logic [7:0] FUNC_SET    = 8'h3B;

    localparam int BF_BIT = 7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin grant; last_grant only advances when the grant is taken.
module lcd_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_grant;

    always_comb begin
        gnt_valid = |req;
        if (req[0] && req[1])
            gnt_id = ~last_grant;
        else
            gnt_id = req[1];
    end

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 1'b1;
        else if (take)
            last_grant <= gnt_id;
    end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Arbitrates two byte writers onto an HD44780 bus and runs write + busy-flag
// polling cycles; all pad-facing outputs are registered.
module lcd_bus_scheduler
    import lcd_bus_pkg::*;
#(
    parameter int T_SETUP  = 2,
    parameter int T_EN     = 12,
    parameter int T_HOLD   = 2,
    parameter int POLL_MAX = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sched_en,
    input  logic       req0,
    input  logic       req1,
    input  logic       rs0,
    input  logic       rs1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       done,
    output logic       done_id,
    output logic       timeout_err,
    output logic       busy,
    output logic       rs_lcd,
    output logic       rw_lcd,
    output logic       en_lcd,
    output logic       oe,
    output logic [7:0] data_out,
    input  logic [7:0] data_in
);

    localparam int PH_MAX = max3(T_SETUP, T_EN, T_HOLD);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int PC_W   = (POLL_MAX > 1) ? $clog2(POLL_MAX + 1) : 1;

    lcd_state_e      state_q, state_d;
    logic [PH_W-1:0] phase_q;
    logic [PC_W-1:0] poll_q;
    logic            rs_q, id_q, bf_q;
    logic [7:0]      data_q;
    logic            gnt_valid, gnt_id, take;
    logic            phase_end, poll_more;
    logic            lat_rs;
    logic [7:0]      lat_data;
    logic            ack0_d, ack1_d, done_d, done_id_d, busy_d;
    logic            rs_d, rw_d, en_d, oe_d;
    logic [7:0]      data_out_d;
    logic            unused_rd;

    assign unused_rd = ^data_in[6:0];

    assign take      = (state_q == IDLE) && sched_en && gnt_valid;
    assign phase_end = (phase_q == '0);
    assign poll_more = (int'(poll_q) + 1) < POLL_MAX;

    lcd_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({req1, req0}),
        .take      (take),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    function automatic logic [PH_W-1:0] phase_load(input lcd_state_e s);
        case (s)
            W_SETUP, R_SETUP: return PH_W'(T_SETUP - 1);
            W_EN, R_EN:       return PH_W'(T_EN - 1);
            W_HOLD, R_HOLD:   return PH_W'(T_HOLD - 1);
            default:          return '0;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = W_SETUP;
            W_SETUP: if (phase_end) state_d = W_EN;
            W_EN:    if (phase_end) state_d = W_HOLD;
            W_HOLD:  if (phase_end) state_d = R_SETUP;
            R_SETUP: if (phase_end) state_d = R_EN;
            R_EN:    if (phase_end) state_d = R_HOLD;
            R_HOLD:  if (phase_end) state_d = (bf_q && poll_more) ? R_SETUP : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transfer context, phase/poll counters and busy-flag sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_q        <= 1'b0;
            data_q      <= '0;
            id_q        <= 1'b0;
            bf_q        <= 1'b0;
            phase_q     <= '0;
            poll_q      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (take) begin
                rs_q   <= lat_rs;
                data_q <= lat_data;
                id_q   <= gnt_id;
            end
            if (state_d != state_q)
                phase_q <= phase_load(state_d);
            else if (!phase_end)
                phase_q <= phase_q - 1'b1;
            if (state_q == R_EN && phase_end)
                bf_q <= data_in[BF_BIT];
            if (state_q == DONE)
                poll_q <= '0;
            else if (state_q == R_HOLD && phase_end && bf_q && poll_more)
                poll_q <= poll_q + 1'b1;
            if (state_q == R_HOLD && phase_end && bf_q && !poll_more)
                timeout_err <= 1'b1;
        end
    end

    // Output decode from the upcoming state, so pins change with the state register.
    always_comb begin
        lat_rs     = take ? (gnt_id ? rs1 : rs0) : rs_q;
        lat_data   = take ? (gnt_id ? data1 : data0) : data_q;
        ack0_d     = take && !gnt_id;
        ack1_d     = take && gnt_id;
        done_d     = 1'b0;
        done_id_d  = 1'b0;
        busy_d     = (state_d != IDLE);
        rs_d       = 1'b0;
        rw_d       = 1'b0;
        en_d       = 1'b0;
        oe_d       = 1'b0;
        data_out_d = '0;
        case (state_d)
            W_SETUP, W_EN, W_HOLD: begin
                oe_d       = 1'b1;
                rs_d       = lat_rs;
                data_out_d = lat_data;
                en_d       = (state_d == W_EN);
            end
            R_SETUP, R_EN, R_HOLD: begin
                rw_d = 1'b1;
                en_d = (state_d == R_EN);
            end
            DONE: begin
                done_d    = 1'b1;
                done_id_d = id_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            done     <= 1'b0;
            done_id  <= 1'b0;
            busy     <= 1'b0;
            rs_lcd   <= 1'b0;
            rw_lcd   <= 1'b0;
            en_lcd   <= 1'b0;
            oe       <= 1'b0;
            data_out <= '0;
        end else begin
            ack0     <= ack0_d;
            ack1     <= ack1_d;
            done     <= done_d;
            done_id  <= done_id_d;
            busy     <= busy_d;
            rs_lcd   <= rs_d;
            rw_lcd   <= rw_d;
            en_lcd   <= en_d;
            oe       <= oe_d;
            data_out <= data_out_d;
        end
    end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Directed + randomized bench; expected pin waveforms are derived from the
// bus-cycle timing rules (phase lengths, read count, round robin).
module tb_lcd_bus_scheduler;

    localparam int TS = 2, TE = 12, TH = 2, PM = 4;
    localparam int P  = TS + TE + TH;

    logic       clk = 1'b0, rst = 1'b1, sched_en = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, rs0 = 1'b0, rs1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0, data_in = '0;
    logic       ack0, ack1, done, done_id, timeout_err, busy;
    logic       rs_lcd, rw_lcd, en_lcd, oe;
    logic [7:0] data_out;

    int n_vec = 0, n_bad = 0;
    bit exp_to = 1'b0;
    bit exp_last = 1'b1;

    lcd_bus_scheduler #(.T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .POLL_MAX(PM)) dut (
        .clk(clk), .rst(rst), .sched_en(sched_en),
        .req0(req0), .req1(req1), .rs0(rs0), .rs1(rs1),
        .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1), .done(done), .done_id(done_id),
        .timeout_err(timeout_err), .busy(busy),
        .rs_lcd(rs_lcd), .rw_lcd(rw_lcd), .en_lcd(en_lcd), .oe(oe),
        .data_out(data_out), .data_in(data_in)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] obs();
        return {ack0, ack1, done, done_id, timeout_err, busy, rs_lcd, rw_lcd, en_lcd, oe};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) return exp_last ? 0 : 1;
        return r1 ? 1 : 0;
    endfunction

    // Expected {ack0,ack1,done,done_id,timeout,busy,rs,rw,en,oe} at cycle c after grant.
    function automatic logic [9:0] exp_vec(input int c, input int id, input bit rs,
                                           input int k, input bit to_b, input bit to_a);
        int  len = P * (k + 1) + 1;
        int  o;
        bit  d = 0, did = 0, to = to_b, rs_e = 0, rw = 0, en = 0, oe_e = 0;
        if (c == len - 1) begin
            d = 1; did = id[0]; to = to_a;
        end else if (c < P) begin
            oe_e = 1; rs_e = rs; en = (c >= TS && c < TS + TE);
        end else begin
            o = (c - P) % P; rw = 1; en = (o >= TS && o < TS + TE);
        end
        return {c == 0 && id == 0, c == 0 && id == 1, d, did, to, 1'b1, rs_e, rw, en, oe_e};
    endfunction

    // Entered at a negedge in IDLE with the grant due on the next posedge.
    task automatic xfer(input int id, input bit rs, input logic [7:0] d,
                        input int nbusy, input bit drop);
        int k    = (nbusy + 1 < PM) ? nbusy + 1 : PM;
        bit to_a = exp_to | (nbusy >= PM);
        int len  = P * (k + 1) + 1;
        int nc, r;
        exp_last = id[0];
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            check($sformatf("xfer id%0d c%0d", id, c), 32'(obs()), 32'(exp_vec(c, id, rs, k, exp_to, to_a)));
            if (c < P) check($sformatf("data_out c%0d", c), 32'(data_out), 32'(d));
            if (c == 0 && drop) begin
                if (id == 0) req0 = 1'b0; else req1 = 1'b0;
            end
            nc = c + 1;
            if (nc >= P && nc < len - 1) begin
                r = (nc - P) / P;
                data_in = {r < nbusy, 7'($urandom)};
            end else begin
                data_in = 8'($urandom);
            end
        end
        exp_to = to_a;
        @(negedge clk);
        check("idle gap", 32'({ack0, ack1, busy, done, timeout_err}), 32'({4'b0, exp_to}));
    endtask

    initial begin
        int id, nb;
        logic [7:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset pins", 32'(obs()), 32'(0));
        check("reset data", 32'(data_out), 32'(0));
        rst = 1'b0;
        sched_en = 1'b1;
        @(negedge clk);
        check("idle", 32'(obs()), 32'(0));

        // Single write, panel immediately ready
        req0 = 1; rs0 = 1; data0 = 8'h50; data_in = 8'h00;
        xfer(pick(1, 0), 1'b1, 8'h50, 0, 1'b1);

        // Both requesting continuously: round robin, new bytes each grant
        req0 = 1; req1 = 1;
        for (int i = 0; i < 4; i++) begin
            rs0 = 1'($urandom); rs1 = 1'($urandom);
            data0 = 8'($urandom); data1 = 8'($urandom);
            id = pick(1, 1);
            xfer(id, id ? rs1 : rs0, id ? data1 : data0, int'($urandom_range(0, 2)), 1'b0);
        end
        req0 = 0; req1 = 0;
        @(negedge clk);

        // Three busy reads then ready
        req0 = 1; rs0 = 0; data0 = 8'h02;
        xfer(pick(1, 0), 1'b0, 8'h02, 3, 1'b1);

        // Busy flag stuck: timeout, then sticky through a good transfer
        req1 = 1; rs1 = 0; data1 = 8'h01;
        xfer(pick(0, 1), 1'b0, 8'h01, 9, 1'b1);
        req0 = 1; rs0 = 1; data0 = 8'h41;
        xfer(pick(1, 0), 1'b1, 8'h41, 0, 1'b1);

        // Grants blocked while sched_en low
        sched_en = 0; req1 = 1; rs1 = 1; data1 = 8'h7E;
        repeat (4) begin
            @(negedge clk);
            check("sched_en low", 32'({ack0, ack1, busy}), 32'(0));
        end
        sched_en = 1;
        xfer(pick(0, 1), 1'b1, 8'h7E, 1, 1'b1);

        // Randomized requests
        for (int i = 0; i < 6; i++) begin
            req0 = 1'($urandom); req1 = 1'($urandom);
            if (!req0 && !req1) req0 = 1;
            rs0 = 1'($urandom); rs1 = 1'($urandom);
            data0 = 8'($urandom); data1 = 8'($urandom);
            id = pick(req0, req1);
            d  = id ? data1 : data0;
            nb = int'($urandom_range(0, 5));
            xfer(id, id ? rs1 : rs0, d, nb, 1'b1);
        end
        req0 = 0; req1 = 0;
        @(negedge clk);

        // Reset in the middle of the write enable pulse
        req0 = 1; rs0 = 1; data0 = 8'hA5;
        repeat (TS + 3) @(negedge clk);
        check("pre-reset en", 32'({en_lcd, oe, rs_lcd}), 32'(3'b111));
        #1 rst = 1'b1;
        #1 check("async reset pins", 32'(obs()), 32'(0));
        @(negedge clk);
        check("reset held", 32'(obs()), 32'(0));
        rst = 1'b0;
        exp_to = 1'b0; exp_last = 1'b1;
        xfer(pick(1, 0), 1'b1, 8'hA5, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
